// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the iterative multiplier sequencer.
//   ALU function codes used by the EX stage, FSM state encodings,
//   default operand width and multiplier bits retired per cycle.
package mul_seq_ctrl_pkg;

    localparam int MUL_XLEN           = 32;
    localparam int MUL_BITS_PER_CYCLE = 2;
    localparam int ALU_FUNC_W         = 5;

    localparam logic [ALU_FUNC_W-1:0] ALU_ADD    = 5'd0;
    localparam logic [ALU_FUNC_W-1:0] ALU_MUL    = 5'd10;
    localparam logic [ALU_FUNC_W-1:0] ALU_MULH   = 5'd11;
    localparam logic [ALU_FUNC_W-1:0] ALU_MULHSU = 5'd12;
    localparam logic [ALU_FUNC_W-1:0] ALU_MULHU  = 5'd13;

    typedef enum logic [1:0] {
        MUL_STATE_IDLE = 2'd0,
        MUL_STATE_BUSY = 2'd1,
        MUL_STATE_DONE = 2'd2
    } mul_state_e;

    // Only the unsigned forms are handled by this unit.
    function automatic logic is_seq_mul(input logic [ALU_FUNC_W-1:0] func);
        return (func == ALU_MUL) || (func == ALU_MULHU);
    endfunction

endpackage

// File: rtl/mul_iter_datapath.sv
// Operand/accumulator datapath for the shift-add multiplier.
//   Holds mcand (2*XLEN), mplier (XLEN) and acc (2*XLEN).
//   i_clear : zero all registers (squash)
//   i_load  : mcand={0,opa}, mplier=opb, acc=0
//   i_step  : acc+=mcand*mplier[BPC-1:0]; mcand<<=BPC; mplier>>=BPC
//   o_acc_next  : accumulator value after the current step
//   o_rest_zero : mplier is zero after the current shift
//                 (port present only with MUL_EARLY_TERM_EN)
import mul_seq_ctrl_pkg::*;

module mul_iter_datapath #(
    parameter int XLEN = MUL_XLEN,
    parameter int BPC  = MUL_BITS_PER_CYCLE
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [XLEN-1:0]   i_opa,
    input  logic [XLEN-1:0]   i_opb,
    output logic [2*XLEN-1:0] o_acc_next
`ifdef MUL_EARLY_TERM_EN
    ,
    output logic              o_rest_zero
`endif
);

    logic [2*XLEN-1:0] r_mcand;
    logic [XLEN-1:0]   r_mplier;
    logic [2*XLEN-1:0] r_acc;
    logic [2*XLEN-1:0] w_digit;
    logic [2*XLEN-1:0] w_partial;

    assign w_digit    = {{(2*XLEN-BPC){1'b0}}, r_mplier[BPC-1:0]};
    assign w_partial  = r_mcand * w_digit;
    assign o_acc_next = r_acc + w_partial;

`ifdef MUL_EARLY_TERM_EN
    assign o_rest_zero = ((r_mplier >> BPC) == '0);
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (i_clear) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (i_load) begin
            r_mcand  <= {{XLEN{1'b0}}, i_opa};
            r_mplier <= i_opb;
            r_acc    <= '0;
        end else if (i_step) begin
            r_acc    <= o_acc_next;
            r_mcand  <= r_mcand << BPC;
            r_mplier <= r_mplier >> BPC;
        end
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencer for the iterative shift-add multiplier (ALU_MUL / ALU_MULHU).
//   i_clk, i_rst (async, active-high)
//   i_start, i_alu_func, i_opa, i_opb : instruction held in ID/EX
//   i_flush  : squash an in-flight multiply
//   o_busy   : stall request to IF/ID and ID/EX (combinational)
//   o_done   : one-cycle pulse, o_result valid
//   o_result : product low half (MUL) or high half (MULHU)
// Optional feature: define MUL_EARLY_TERM_EN to leave BUSY as soon as the
// remaining multiplier bits are all zero.
//
// state | meaning
// IDLE  | waiting for a multiply in ID/EX
// BUSY  | retiring BITS_PER_CYCLE multiplier bits per cycle
// DONE  | result register valid, done pulse high
import mul_seq_ctrl_pkg::*;

module mul_seq_ctrl #(
    parameter int XLEN           = MUL_XLEN,
    parameter int BITS_PER_CYCLE = MUL_BITS_PER_CYCLE
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ALU_FUNC_W-1:0] i_alu_func,
    input  logic [XLEN-1:0]       i_opa,
    input  logic [XLEN-1:0]       i_opb,
    input  logic                  i_flush,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [XLEN-1:0]       o_result
);

    localparam int ITER  = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITER);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mul_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_hi_sel;
    logic              r_done;
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic              w_in_busy;
    logic              w_last;
    logic [2*XLEN-1:0] w_acc_next;

    assign w_in_busy = (r_state == MUL_STATE_BUSY);
    assign w_accept  = (r_state == MUL_STATE_IDLE) && i_start
                       && is_seq_mul(i_alu_func) && !i_flush;

`ifdef MUL_EARLY_TERM_EN
    logic w_rest_zero;
    assign w_last = (r_cnt == CNT_ONE) || w_rest_zero;
`else
    assign w_last = (r_cnt == CNT_ONE);
`endif

    mul_iter_datapath #(
        .XLEN (XLEN),
        .BPC  (BITS_PER_CYCLE)
    ) u_datapath (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (w_in_busy && i_flush),
        .i_load     (w_accept),
        .i_step     (w_in_busy && !i_flush),
        .i_opa      (i_opa),
        .i_opb      (i_opb),
        .o_acc_next (w_acc_next)
`ifdef MUL_EARLY_TERM_EN
        ,
        .o_rest_zero(w_rest_zero)
`endif
    );

    // Stall already in the accept cycle so ID/EX holds the instruction.
    assign o_busy   = w_in_busy || w_accept;
    assign o_done   = r_done;
    assign o_result = r_result;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= MUL_STATE_IDLE;
            r_cnt    <= '0;
            r_hi_sel <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MUL_STATE_IDLE: begin
                    if (w_accept) begin
                        r_state  <= MUL_STATE_BUSY;
                        r_cnt    <= CNT_LOAD;
                        r_hi_sel <= (i_alu_func == ALU_MULHU);
                    end
                end
                MUL_STATE_BUSY: begin
                    if (i_flush) begin
                        r_state <= MUL_STATE_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                        if (w_last) begin
                            // Capture the accumulator including this final step.
                            r_state  <= MUL_STATE_DONE;
                            r_done   <= 1'b1;
                            r_result <= r_hi_sel ? w_acc_next[2*XLEN-1:XLEN]
                                                 : w_acc_next[XLEN-1:0];
                        end
                    end
                end
                // Already committed to EX/MEM: flush and start are ignored here.
                MUL_STATE_DONE: r_state <= MUL_STATE_IDLE;
                default:        r_state <= MUL_STATE_IDLE;
            endcase
        end
    end

endmodule
